cke_gen_multi: RTL and testbench
================================

Name: cke_gen_multi

Overview:
- Parametrised multi-channel clock-enable generator.
- Runs on the free-running system clock and produces N_CH independent clock-enable pulse trains.
- Each train has a programmable divide ratio and phase offset, with synchronised start and a graceful per-channel stop.
- Drives the *_ce inputs of the MMCM clock-gating outputs (TX, RX rising, RX falling, ...). This replaces hand-built enable logic with one configurable block.

Parameters:
- N_CH, 3, number of clock-enable channels (1..16).
- DIV_W, 16, width of divide and phase fields; period range 1..2^DIV_W cycles.
- CH_W, $clog2(N_CH) (min 1), width of the channel select.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  CH_W  channel addressed by cfg_we.
- cfg_div  in  DIV_W  period minus one (0 = enable every cycle).
- cfg_phase  in  DIV_W  cycles from run entry to first pulse.
- start  in  1  single-cycle request to start all configured channels together.
- stop  in  1  single-cycle request to stop all channels after their next pulse.
- cke  out  N_CH  clock-enable outputs, one per channel.
- busy  out  1  high while any channel is running or draining.
- cfg_err  out  1  one-cycle pulse when a config write is rejected.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - cke=0, busy=0, cfg_err=0.
  - All channels: div=0, phase=0, enabled=0; FSM=IDLE.
- Config:
  - cfg_we in IDLE with cfg_ch<N_CH writes div, phase and sets enabled[cfg_ch]=1.
  - Effective phase = min(cfg_phase, cfg_div).
  - cfg_we in RUN/DRAIN, or with cfg_ch>=N_CH: write ignored; cfg_err=1 next cycle.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE->RUN: start sampled high at edge t.
    - busy=1 from cycle t+1.
    - Each enabled channel counter is loaded with its effective phase at that edge.
  - RUN: each running channel asserts cke[i] when its counter==0, reloads div, and otherwise decrements.
    - First pulse of channel i occurs in cycle t+1+phase_i; subsequent pulses every div_i+1 cycles.
    - Disabled channels hold cke[i]=0.
  - RUN->DRAIN: stop sampled high. Each channel's next pulse is its last.
    - A pulse in the same cycle stop is sampled counts as that last pulse.
    - After the last pulse the channel's run flag clears.
  - DRAIN->IDLE: the cycle after the last running channel emits its final pulse; busy=0 from that cycle.
- start while busy: ignored.
- stop in IDLE: ignored. start and stop in the same IDLE cycle: start taken, stop ignored.
- start with no channel enabled: FSM stays in IDLE, busy stays 0.
- cke is decoded from registered state only; no combinational path from any input to cke.
- Counter wrap: div=2^DIV_W-1 gives the maximum period with no overflow; the counter never underflows past 0.
- Async reset mid-RUN: cke drops immediately; configuration is lost.

Optional Feature:
- Macro: CKE_GEN_PULSE_CNT_EN.
- Defined: adds ports cnt_sel (in, CH_W) and cnt_q (out, 32).
  - Each channel has a 32-bit saturating count of cke pulses.
  - Counts clear on start acceptance and on reset.
  - cnt_q is registered, reflecting cnt_sel with 1-cycle latency.
  - cnt_sel>=N_CH returns 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package cke_gen_pkg:
  - FSM state enum (IDLE/RUN/DRAIN).
  - Per-channel config struct {enabled, div, phase}, parametrised via DIV_W localparam default.
  - MAX_CH=16 constant.
- Sub-module cke_gen_ch: one channel's counter, run/last-pulse flags and cke output.
  - Driven by load/stop_req strobes from the top FSM.
  - Returns a running flag.
  - Instantiated N_CH times in a generate loop.

Test Plan:
- Reset-then-idle: hold rst_n=0 for 5 cycles, then release → cke=0, busy=0; start with no config → busy stays 0.
- Basic divide: ch0 div=3 phase=0, start at cycle 10 → cke[0] high at 11, 15, 19, ...; busy high from 11.
- Phase and clamp (N_CH=3):
  - ch0 div=4 phase=1 → pulses at 12, 17, ...
  - ch1 div=4 phase=9 (clamped to 4) → pulses at 15, 20, ...
  - ch2 div=0 → cke[2] high every cycle from 11.
  - Start at cycle 10.
- Graceful stop: ch0 div=7, ch1 div=2, stop mid-run → each channel emits exactly one more pulse; busy falls the cycle after ch0's final pulse.
- Config rejection:
  - cfg_we during RUN → cfg_err pulses one cycle, divide unchanged.
  - cfg_ch=3 with N_CH=3 in IDLE → cfg_err pulses.
- Async reset mid-RUN: assert rst_n between pulses → cke=0 and busy=0 immediately; after release, start alone gives no pulses until reconfigured.

Source files
------------

// File: rtl/cke_gen_pkg.sv
// cke_gen_pkg: shared types and constants for the multi-channel clock-enable generator.
//   state_t   - controller FSM state (IDLE / RUN / DRAIN)
//   ch_cfg_t  - per-channel configuration record {enabled, div, phase} at the
//               default field width DIV_W_DEF
//   MAX_CH    - largest supported channel count
package cke_gen_pkg;

   localparam int MAX_CH    = 16;
   localparam int DIV_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic                 enabled;
      logic [DIV_W_DEF-1:0] div;
      logic [DIV_W_DEF-1:0] phase;
   } ch_cfg_t;

endpackage

// File: rtl/cke_gen_ch.sv
// cke_gen_ch: one clock-enable channel.
// The channel counts down from its phase to 0, pulses cke, then reloads div.
// A stop request arms a last-pulse flag. The next pulse, or a pulse in the same
// cycle as the request, is the final one.
// Ports:
//   clk_sys, rst_n   - system clock, async active-low reset
//   load             - start accepted: load phase (if enabled) and begin running
//   stop_req         - graceful stop request from the controller
//   enabled          - channel has been configured
//   div, phase       - period minus one and effective (already clamped) phase
//   cke              - enable pulse, decoded from registered counter/run state
//   running          - channel is still running after the current clock edge
module cke_gen_ch
   import cke_gen_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk_sys,
   input  logic             rst_n,
   input  logic             load,
   input  logic             stop_req,
   input  logic             enabled,
   input  logic [DIV_W-1:0] div,
   input  logic [DIV_W-1:0] phase,
   output logic             cke,
   output logic             running
);

   logic [DIV_W-1:0] cnt_r;
   logic             run_r;
   logic             last_r;
   logic [DIV_W-1:0] cnt_d_s;
   logic             run_d_s;
   logic             last_d_s;
   logic             hit_s;

   // Next-state logic for the counter, run flag and last-pulse flag.
   always_comb begin
      hit_s    = run_r && (cnt_r == {DIV_W{1'b0}});
      cnt_d_s  = cnt_r;
      run_d_s  = run_r;
      last_d_s = last_r;
      if (load) begin
         last_d_s = 1'b0;
         if (enabled) begin
            cnt_d_s = phase;
            run_d_s = 1'b1;
         end else begin
            cnt_d_s = {DIV_W{1'b0}};
            run_d_s = 1'b0;
         end
      end else if (run_r) begin
         if (hit_s) begin
            // Reload on the pulse. A pending stop, or a stop in this very
            // cycle, makes this pulse the last one.
            cnt_d_s = div;
            if (last_r || stop_req) begin
               run_d_s  = 1'b0;
               last_d_s = 1'b0;
            end else begin
               run_d_s  = 1'b1;
               last_d_s = 1'b0;
            end
         end else begin
            // cnt_r is non-zero here, so the decrement cannot underflow.
            cnt_d_s = cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
            if (stop_req) begin
               last_d_s = 1'b1;
            end else begin
               last_d_s = last_r;
            end
         end
      end else begin
         cnt_d_s  = cnt_r;
         run_d_s  = 1'b0;
         last_d_s = 1'b0;
      end
   end

   // Channel state registers.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r  <= {DIV_W{1'b0}};
         run_r  <= 1'b0;
         last_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_d_s;
         run_r  <= run_d_s;
         last_r <= last_d_s;
      end
   end

   assign cke     = hit_s;
   assign running = run_d_s;

endmodule

// File: rtl/cke_gen_multi.sv
// cke_gen_multi: N_CH independent clock-enable pulse trains with programmable
// divide and phase, a synchronised start and a graceful stop.
// Optional feature macro: CKE_GEN_PULSE_CNT_EN adds per-channel 32-bit
// saturating pulse counters, read back through cnt_sel / cnt_q.
// Ports:
//   clk_sys, rst_n           - system clock, async active-low reset
//   cfg_we, cfg_ch           - config write strobe and target channel (IDLE only)
//   cfg_div, cfg_phase       - period minus one, cycles from start to first pulse
//   start, stop              - run all enabled channels / stop after next pulse
//   cke                      - per-channel clock enables
//   busy                     - any channel running or draining
//   cfg_err                  - one-cycle pulse for a rejected config write
//   cnt_sel, cnt_q           - (CKE_GEN_PULSE_CNT_EN) pulse-count readback
module cke_gen_multi
   import cke_gen_pkg::*;
#(
   parameter int N_CH  = 3,
   parameter int DIV_W = DIV_W_DEF,
   parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk_sys,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic [DIV_W-1:0] cfg_phase,
   input  logic             start,
   input  logic             stop,
`ifdef CKE_GEN_PULSE_CNT_EN
   input  logic [CH_W-1:0]  cnt_sel,
   output logic [31:0]      cnt_q,
`endif
   output logic [N_CH-1:0]  cke,
   output logic             busy,
   output logic             cfg_err
);

   typedef struct packed {
      logic             enabled;
      logic [DIV_W-1:0] div;
      logic [DIV_W-1:0] phase;
   } cfg_t;

   cfg_t             cfg_r [N_CH];
   logic             cfg_err_r;
   state_t           state_r;
   state_t           state_d_s;
   logic             cfg_ok_s;
   logic [DIV_W-1:0] phase_eff_s;
   logic             load_s;
   logic             stop_req_s;
   logic [N_CH-1:0]  en_s;
   logic [N_CH-1:0]  run_nxt_s;
   logic [N_CH-1:0]  cke_s;

   assign cfg_ok_s    = cfg_we && (state_r == ST_IDLE) && (32'(cfg_ch) < 32'(N_CH));
   // A phase longer than the period would delay only the first pulse oddly;
   // clamp it to the period so the first pulse lands within one period.
   assign phase_eff_s = (cfg_phase > cfg_div) ? cfg_div : cfg_phase;
   assign load_s      = (state_r == ST_IDLE) && start && (|en_s);
   assign stop_req_s  = (state_r == ST_RUN) && stop;

   // Configuration storage and write-rejection flag.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            cfg_r[i] <= {(2*DIV_W+1){1'b0}};
         end
         cfg_err_r <= 1'b0;
      end else begin
         cfg_err_r <= cfg_we && !cfg_ok_s;
         if (cfg_ok_s) begin
            cfg_r[cfg_ch] <= '{enabled: 1'b1, div: cfg_div, phase: phase_eff_s};
         end
      end
   end

   // Controller next-state logic.
   always_comb begin
      state_d_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (load_s) begin
               state_d_s = ST_RUN;
            end else begin
               state_d_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!(|run_nxt_s)) begin
               state_d_s = ST_IDLE;
            end else if (stop) begin
               state_d_s = ST_DRAIN;
            end else begin
               state_d_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (!(|run_nxt_s)) begin
               state_d_s = ST_IDLE;
            end else begin
               state_d_s = ST_DRAIN;
            end
         end
         default: state_d_s = ST_IDLE;
      endcase
   end

   // Controller state register.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_d_s;
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      assign en_s[g] = cfg_r[g].enabled;
      cke_gen_ch #(.DIV_W(DIV_W)) u_ch (
         .clk_sys  (clk_sys),
         .rst_n    (rst_n),
         .load     (load_s),
         .stop_req (stop_req_s),
         .enabled  (cfg_r[g].enabled),
         .div      (cfg_r[g].div),
         .phase    (cfg_r[g].phase),
         .cke      (cke_s[g]),
         .running  (run_nxt_s[g])
      );
   end

`ifdef CKE_GEN_PULSE_CNT_EN
   logic [31:0] pcnt_r [N_CH];
   logic [31:0] cnt_q_r;

   // Per-channel saturating pulse counters and registered readback.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            pcnt_r[i] <= 32'd0;
         end
         cnt_q_r <= 32'd0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (load_s) begin
               pcnt_r[i] <= 32'd0;
            end else if (cke_s[i] && (pcnt_r[i] != 32'hFFFF_FFFF)) begin
               pcnt_r[i] <= pcnt_r[i] + 32'd1;
            end else begin
               pcnt_r[i] <= pcnt_r[i];
            end
         end
         if (32'(cnt_sel) < 32'(N_CH)) begin
            cnt_q_r <= pcnt_r[cnt_sel];
         end else begin
            cnt_q_r <= 32'd0;
         end
      end
   end

   assign cnt_q = cnt_q_r;
`endif

   assign cke     = cke_s;
   assign busy    = (state_r != ST_IDLE);
   assign cfg_err = cfg_err_r;

endmodule

// File: tb/tb_cke_gen_multi.sv
// Directed self-checking bench for cke_gen_multi (N_CH=3, DIV_W=16).
// Cycle index k counts cycles after the edge that accepts start: k=0 is the
// first cycle with busy high.
module tb_cke_gen_multi;

   localparam int N_CH  = 3;
   localparam int DIV_W = 16;
   localparam int CH_W  = 2;

   logic             clk_sys = 1'b0;
   logic             rst_n = 1'b0;
   logic             cfg_we = 1'b0;
   logic [CH_W-1:0]  cfg_ch = 2'd0;
   logic [DIV_W-1:0] cfg_div = 16'd0;
   logic [DIV_W-1:0] cfg_phase = 16'd0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic [N_CH-1:0]  cke;
   logic             busy;
   logic             cfg_err;
   int               err_cnt = 0;
   int               chk_cnt = 0;
`ifdef CKE_GEN_PULSE_CNT_EN
   logic [CH_W-1:0]  cnt_sel = 2'd0;
   logic [31:0]      cnt_q;
`endif

   always #5 clk_sys = ~clk_sys;

   cke_gen_multi #(.N_CH(N_CH), .DIV_W(DIV_W), .CH_W(CH_W)) dut (
      .clk_sys   (clk_sys),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_phase (cfg_phase),
      .start     (start),
      .stop      (stop),
`ifdef CKE_GEN_PULSE_CNT_EN
      .cnt_sel   (cnt_sel),
      .cnt_q     (cnt_q),
`endif
      .cke       (cke),
      .busy      (busy),
      .cfg_err   (cfg_err)
   );

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      cfg_we = 1'b0;
      start = 1'b0;
      stop = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic write_cfg(input int ch, input int div, input int ph);
      cfg_we    = 1'b1;
      cfg_ch    = CH_W'(ch);
      cfg_div   = DIV_W'(div);
      cfg_phase = DIV_W'(ph);
      tick();
      cfg_we    = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (5) tick();
      chk_cnt++;
      if ({cke, busy, cfg_err} !== 5'b0) begin
         err_cnt++;
         $display("FAIL reset_outputs cke=%b busy=%b cfg_err=%b want all 0", cke, busy, cfg_err);
      end
      rst_n = 1'b1;
      tick();
      do_start();
      for (int k = 0; k < 4; k++) begin
         chk_cnt++;
         if ({cke, busy} !== 4'b0) begin
            err_cnt++;
            $display("FAIL start_unconfigured k=%0d cke=%b busy=%b want 0", k, cke, busy);
         end
         tick();
      end
   endtask

   task automatic test_basic_divide();
      logic [N_CH-1:0] exp;
      apply_reset();
      write_cfg(0, 3, 0);
      do_start();
      for (int k = 0; k < 12; k++) begin
         exp = (k % 4 == 0) ? 3'b001 : 3'b000;
         chk_cnt++;
         if (cke !== exp || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL basic_divide k=%0d cke=%b busy=%b want cke=%b busy=1", k, cke, busy, exp);
         end
         tick();
      end
`ifdef CKE_GEN_PULSE_CNT_EN
      cnt_sel = 2'd0;
      tick();
      chk_cnt++;
      if (cnt_q !== 32'd3) begin
         err_cnt++;
         $display("FAIL pulse_count got %0d want 3", cnt_q);
      end
      cnt_sel = 2'd3;
      tick();
      chk_cnt++;
      if (cnt_q !== 32'd0) begin
         err_cnt++;
         $display("FAIL pulse_count_badsel got %0d want 0", cnt_q);
      end
`endif
   endtask

   task automatic test_phase_clamp();
      logic [N_CH-1:0] exp;
      apply_reset();
      write_cfg(0, 4, 1);
      write_cfg(1, 4, 9);
      write_cfg(2, 0, 0);
      do_start();
      for (int k = 0; k < 15; k++) begin
         exp[0] = (k >= 1) && ((k - 1) % 5 == 0);
         exp[1] = (k >= 4) && ((k - 4) % 5 == 0);
         exp[2] = 1'b1;
         chk_cnt++;
         if (cke !== exp) begin
            err_cnt++;
            $display("FAIL phase_clamp k=%0d cke=%b want %b", k, cke, exp);
         end
         tick();
      end
   endtask

   task automatic test_graceful_stop();
      logic [N_CH-1:0] exp;
      logic            exp_busy;
      apply_reset();
      write_cfg(0, 7, 0);
      write_cfg(1, 2, 0);
      do_start();
      // stop is sampled at the end of k=4: ch1's last pulse is k=6, ch0's is k=8.
      for (int k = 0; k < 13; k++) begin
         exp[0]   = (k == 0) || (k == 8);
         exp[1]   = (k == 0) || (k == 3) || (k == 6);
         exp[2]   = 1'b0;
         exp_busy = (k <= 8);
         chk_cnt++;
         if (cke !== exp || busy !== exp_busy) begin
            err_cnt++;
            $display("FAIL graceful_stop k=%0d cke=%b busy=%b want cke=%b busy=%b", k, cke, busy, exp, exp_busy);
         end
         stop = (k == 4);
         tick();
      end
      stop = 1'b0;
   endtask

   task automatic test_stop_on_pulse();
      logic exp_cke;
      apply_reset();
      write_cfg(0, 3, 0);
      // start and stop together in IDLE: start wins, stop is dropped.
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      // A stop sampled in the pulse cycle k=8 makes that pulse the last.
      for (int k = 0; k < 12; k++) begin
         exp_cke = (k % 4 == 0) && (k <= 8);
         chk_cnt++;
         if (cke[0] !== exp_cke || busy !== (k <= 8)) begin
            err_cnt++;
            $display("FAIL stop_on_pulse k=%0d cke0=%b busy=%b want cke0=%b busy=%b", k, cke[0], busy, exp_cke, (k <= 8));
         end
         stop = (k == 8);
         tick();
      end
      stop = 1'b0;
   endtask

   task automatic test_cfg_reject();
      apply_reset();
      write_cfg(0, 3, 0);
      do_start();
      for (int k = 0; k < 9; k++) begin
         chk_cnt++;
         if (cke[0] !== (k % 4 == 0) || cfg_err !== (k == 1)) begin
            err_cnt++;
            $display("FAIL cfg_reject_run k=%0d cke0=%b cfg_err=%b want cke0=%b cfg_err=%b", k, cke[0], cfg_err, (k % 4 == 0), (k == 1));
         end
         // k=0: write during RUN is rejected; k=2: start while busy is ignored.
         cfg_we    = (k == 0);
         cfg_ch    = 2'd0;
         cfg_div   = 16'd1;
         cfg_phase = 16'd0;
         start     = (k == 2);
         tick();
      end
      cfg_we = 1'b0;
      start  = 1'b0;
      apply_reset();
      write_cfg(3, 2, 0);
      chk_cnt++;
      if (cfg_err !== 1'b1) begin
         err_cnt++;
         $display("FAIL cfg_reject_ch got cfg_err=%b want 1", cfg_err);
      end
      tick();
      chk_cnt++;
      if (cfg_err !== 1'b0) begin
         err_cnt++;
         $display("FAIL cfg_err_one_cycle got cfg_err=%b want 0", cfg_err);
      end
      write_cfg(2, 1, 0);
      chk_cnt++;
      if (cfg_err !== 1'b0) begin
         err_cnt++;
         $display("FAIL cfg_accept got cfg_err=%b want 0", cfg_err);
      end
   endtask

   task automatic test_max_div();
      apply_reset();
      write_cfg(1, 65535, 2);
      do_start();
      for (int k = 0; k < 8; k++) begin
         chk_cnt++;
         if (cke !== ((k == 2) ? 3'b010 : 3'b000)) begin
            err_cnt++;
            $display("FAIL max_div k=%0d cke=%b want %b", k, cke, ((k == 2) ? 3'b010 : 3'b000));
         end
         tick();
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      write_cfg(0, 3, 0);
      do_start();
      repeat (4) tick();
      chk_cnt++;
      if (cke[0] !== 1'b1) begin
         err_cnt++;
         $display("FAIL async_pre_pulse cke0=%b want 1", cke[0]);
      end
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if (cke !== 3'b000 || busy !== 1'b0) begin
         err_cnt++;
         $display("FAIL async_reset_drop cke=%b busy=%b want 0", cke, busy);
      end
      tick();
      rst_n = 1'b1;
      tick();
      do_start();
      for (int k = 0; k < 8; k++) begin
         chk_cnt++;
         if ({cke, busy} !== 4'b0) begin
            err_cnt++;
            $display("FAIL async_cfg_lost k=%0d cke=%b busy=%b want 0", k, cke, busy);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic_divide();
      test_phase_clamp();
      test_graceful_stop();
      test_stop_on_pulse();
      test_cfg_reject();
      test_max_div();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
